// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for counters and FIFO pointer logic.
// Operands are GRAY_MAX_WIDTH wide; narrower values are zero-extended, which leaves both transforms exact.
package gray_pkg;

  localparam int unsigned GRAY_MAX_WIDTH = 16;

  typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down, built by log2 doubling steps.
  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b = g;
    for (int unsigned s = 1; s < GRAY_MAX_WIDTH; s = s << 1) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_n.sv
// Combinational Gray-to-binary converter; each binary bit is the XOR of all Gray bits at or above it.
module gray2bin_n #(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/gray_counter_n.sv
// Parametrised Gray-code counter with load, clear, sticky wrap flags and a binary shadow output.
// Down-counting and Underflow exist only when GRAY_DOWN_EN is defined; otherwise Dir is ignored.
module gray_counter_n
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             En,
  input  logic             Dir,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             Clear,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Binary,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Wrap
);

  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(RESET_VAL)));
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX_BIN  = '1;

  logic [WIDTH-1:0] bin_q, bin_d, gray_q, load_bin;
  logic             ovf_q, ovf_d, wrap_q, wrap_d;

  gray2bin_n #(.WIDTH(WIDTH)) u_load_conv (
    .gray (LoadVal),
    .bin  (load_bin)
  );

`ifdef GRAY_DOWN_EN
  logic unf_q, unf_d;
`else
  logic unused_dir;
  assign unused_dir = Dir;
`endif

  // Next index and flags; priority Clear > Load > En.
  always_comb begin
    bin_d  = bin_q;
    ovf_d  = ovf_q;
    wrap_d = 1'b0;
`ifdef GRAY_DOWN_EN
    unf_d  = unf_q;
`endif
    if (Clear) begin
      bin_d = RST_BIN;
      ovf_d = 1'b0;
`ifdef GRAY_DOWN_EN
      unf_d = 1'b0;
`endif
    end else if (Load) begin
      bin_d = load_bin;
    end else if (En) begin
`ifdef GRAY_DOWN_EN
      if (!Dir) begin
        bin_d = bin_q - ONE;
        if (bin_q == '0) begin
          unf_d  = 1'b1;
          wrap_d = 1'b1;
        end
      end else
`endif
      begin
        bin_d = bin_q + ONE;
        if (bin_q == MAX_BIN) begin
          ovf_d  = 1'b1;
          wrap_d = 1'b1;
        end
      end
    end
  end

  // Gray output is registered from the next binary index so both outputs change together.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bin_q  <= RST_BIN;
      gray_q <= RST_GRAY;
      ovf_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= WIDTH'(bin2gray(GRAY_MAX_WIDTH'(bin_d)));
      ovf_q  <= ovf_d;
      wrap_q <= wrap_d;
    end
  end

`ifdef GRAY_DOWN_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      unf_q <= 1'b0;
    end else begin
      unf_q <= unf_d;
    end
  end

  assign Underflow = unf_q;
`else
  assign Underflow = 1'b0;
`endif

  assign Output   = gray_q;
  assign Binary   = bin_q;
  assign Overflow = ovf_q;
  assign Wrap     = wrap_q;

endmodule

// File: tb/tb_gray_counter_n.sv
// Self-checking bench for gray_counter_n: two instances (RESET_VAL 0 and 2) against an index-level model.
// Down-count expectations follow GRAY_DOWN_EN as seen by this bench.
module tb_gray_counter_n;

  localparam int unsigned W = 3;
  localparam int MOD = 8;

  logic         clk = 1'b0;
  logic         rst_n, en, dir, load, clr;
  logic [W-1:0] lv;
  logic [W-1:0] out0, bin0, out2, bin2;
  logic         ov0, un0, wr0, ov2, un2, wr2;

  int nchecks = 0;
  int nerr    = 0;
  bit chk_en  = 1'b0;

  int rv     [2] = '{0, 2};
  int m_idx  [2] = '{0, 2};
  int m_prev [2] = '{0, 2};
  int m_ovf  [2] = '{0, 0};
  int m_unf  [2] = '{0, 0};
  int m_wrap [2] = '{0, 0};
  bit m_step [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  gray_counter_n #(.WIDTH(W), .RESET_VAL(0)) dut0 (
    .Clk(clk), .Reset_n(rst_n), .En(en), .Dir(dir), .Load(load), .LoadVal(lv), .Clear(clr),
    .Output(out0), .Binary(bin0), .Overflow(ov0), .Underflow(un0), .Wrap(wr0)
  );

  gray_counter_n #(.WIDTH(W), .RESET_VAL(2)) dut2 (
    .Clk(clk), .Reset_n(rst_n), .En(en), .Dir(dir), .Load(load), .LoadVal(lv), .Clear(clr),
    .Output(out2), .Binary(bin2), .Overflow(ov2), .Underflow(un2), .Wrap(wr2)
  );

  function automatic int gray_of(int i);
    return i ^ (i >> 1);
  endfunction

  // Inverse by search over the code table rather than by formula.
  function automatic int index_of(int g);
    for (int i = 0; i < MOD; i++) begin
      if (gray_of(i) == g) return i;
    end
    return -1;
  endfunction

  function automatic bit counting_down();
`ifdef GRAY_DOWN_EN
    return !dir;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(string name, int act, int exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an integer index per instance, stepped modulo 2^W.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      m_prev[k] = m_idx[k];
      m_step[k] = 1'b0;
      if (!rst_n || clr) begin
        m_idx[k]  = rv[k];
        m_ovf[k]  = 0;
        m_unf[k]  = 0;
        m_wrap[k] = 0;
      end else if (load) begin
        m_idx[k]  = index_of(int'(lv));
        m_wrap[k] = 0;
      end else if (en) begin
        m_step[k] = 1'b1;
        if (counting_down()) begin
          m_wrap[k] = (m_idx[k] == 0) ? 1 : 0;
          if (m_wrap[k] == 1) m_unf[k] = 1;
          m_idx[k] = (m_idx[k] + MOD - 1) % MOD;
        end else begin
          m_wrap[k] = (m_idx[k] == MOD - 1) ? 1 : 0;
          if (m_wrap[k] == 1) m_ovf[k] = 1;
          m_idx[k] = (m_idx[k] + 1) % MOD;
        end
      end else begin
        m_wrap[k] = 0;
      end
    end
  end

  task automatic check_dut(int k, logic [W-1:0] o, logic [W-1:0] b, logic ov, logic un, logic wr);
    string t;
    t = (k == 0) ? "d0" : "d2";
    chk({t, ".output"},    int'(o),  gray_of(m_idx[k]));
    chk({t, ".binary"},    int'(b),  m_idx[k]);
    chk({t, ".overflow"},  int'(ov), m_ovf[k]);
    chk({t, ".underflow"}, int'(un), m_unf[k]);
    chk({t, ".wrap"},      int'(wr), m_wrap[k]);
    if (m_step[k]) chk({t, ".onebit"}, $countones(o ^ W'(gray_of(m_prev[k]))), 1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check_dut(0, out0, bin0, ov0, un0, wr0);
        check_dut(1, out2, bin2, ov2, un2, wr2);
      end
    end
  end

  task automatic cyc(bit e, bit d, bit l, logic [W-1:0] v, bit c);
    en = e; dir = d; load = l; lv = v; clr = c;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] up_seq [0:8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};

  initial begin
    rst_n = 1'b1; en = 1'b0; dir = 1'b1; load = 1'b0; clr = 1'b0; lv = '0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out0", int'(out0), 0);
    chk("rst_out2", int'(out2), 3);
    chk("rst_bin2", int'(bin2), 2);
    chk("rst_flags", int'({ov0, un0, wr0, ov2, un2, wr2}), 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Full up cycle from reset, wrapping once.
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 1, 0, '0, 0);
      chk("up_seq", int'(out0), int'(up_seq[i]));
      chk("up_bin", int'(bin0), i % 8);
      chk("up_wrap", int'(wr0), (i == 8) ? 1 : 0);
    end
    chk("up_ovf", int'(ov0), 1);
    cyc(0, 1, 0, '0, 0);
    chk("wrap_drop", int'(wr0), 0);
    chk("ovf_sticky", int'(ov0), 1);

    // Load wins over En; flags untouched.
    cyc(1, 1, 1, 3'b110, 0);
    chk("load_out", int'(out0), 3'b110);
    chk("load_bin", int'(bin0), 4);
    chk("load_ovf", int'(ov0), 1);
    cyc(1, 1, 0, '0, 0);
    chk("after_load_out", int'(out0), 3'b111);
    chk("after_load_bin", int'(bin0), 5);
    chk("after_load_ovf", int'(ov0), 1);

    // Clear dominates Load and En.
    chk("pre_clear_ovf2", int'(ov2), 1);
    cyc(1, 1, 1, 3'b101, 1);
    chk("clr_out2", int'(out2), 3'b011);
    chk("clr_bin2", int'(bin2), 2);
    chk("clr_ovf2", int'(ov2), 0);
    chk("clr_wrap2", int'(wr2), 0);
    chk("clr_out0", int'(out0), 0);

    // Count to 110 with Overflow set, then pulse reset between edges.
    for (int i = 0; i < 12; i++) cyc(1, 1, 0, '0, 0);
    chk("pre_rst_out0", int'(out0), 3'b110);
    chk("pre_rst_ovf0", int'(ov0), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out0", int'(out0), 0);
    chk("async_bin0", int'(bin0), 0);
    chk("async_out2", int'(out2), 3'b011);
    chk("async_flags", int'({ov0, un0, wr0, ov2, un2, wr2}), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("resume_out0", int'(out0), 3'b001);
    chk("resume_bin0", int'(bin0), 1);

    // Down step from zero.
    cyc(0, 1, 0, '0, 1);
    cyc(1, 0, 0, '0, 0);
`ifdef GRAY_DOWN_EN
    chk("down_out", int'(out0), 3'b100);
    chk("down_bin", int'(bin0), 7);
    chk("down_unf", int'(un0), 1);
    chk("down_wrap", int'(wr0), 1);
    chk("down_ovf", int'(ov0), 0);
`else
    chk("nodown_out", int'(out0), 3'b001);
    chk("nodown_unf", int'(un0), 0);
`endif
    cyc(0, 0, 0, '0, 0);
    chk("down_wrap_drop", int'(wr0), 0);

    // Mixed directed vectors, checked against the model each cycle.
    for (int i = 0; i < 48; i++) begin
      cyc((i % 5) != 0, ((i / 6) % 2) == 1, (i % 11) == 3, W'(i % 8), i == 29);
    end
    cyc(0, 1, 1, 3'b100, 0);
    chk("load_100_bin", int'(bin0), 7);
    cyc(0, 1, 0, '0, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
